// File: rtl/ring_vc_router.sv
// ring_vc_router: bidirectional ring router with per-direction VC slots, round-robin selection, host inject/eject and drop counters
module ring_vc_router #(
  parameter int ROUTER_ID   = 0,
  parameter int PACKET_SIZE = 8,
  parameter int ROUTER_BITS = 2,
  parameter int NUM_VC      = 2,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PACKET_SIZE-1:0] left_data_in,
  input  logic                   left_enable_in,
  output logic                   left_out_buffer_full,
  output logic [PACKET_SIZE-1:0] right_data_out,
  output logic                   right_enable_out,
  input  logic                   right_in_buffer_full,
  input  logic [PACKET_SIZE-1:0] right_data_in,
  input  logic                   right_enable_in,
  output logic                   right_out_buffer_full,
  output logic [PACKET_SIZE-1:0] left_data_out,
  output logic                   left_enable_out,
  input  logic                   left_in_buffer_full,
  input  logic [PACKET_SIZE-1:0] host_data_in,
  input  logic                   host_enable_in,
  input  logic                   host_dir,
  output logic                   host_ready,
  output logic [PACKET_SIZE-1:0] host_data_out,
  output logic                   host_valid_out,
  output logic [CNT_W-1:0]       lr_drop_cnt,
  output logic [CNT_W-1:0]       rl_drop_cnt
);
  localparam int PW = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
  localparam logic [ROUTER_BITS-1:0] ID = ROUTER_BITS'(ROUTER_ID);
  // index 0 is the LR direction, index 1 the RL direction
  logic [NUM_VC-1:0]      vld [2];
  logic [PACKET_SIZE-1:0] mem [2][NUM_VC];
  logic [PW-1:0]          rr [2];
  logic [PW-1:0]          sel [2];
  logic [PW-1:0]          widx [2];
  logic [PACKET_SIZE-1:0] sel_data [2];
  logic [PACKET_SIZE-1:0] in_data [2];
  logic [PACKET_SIZE-1:0] out_q [2];
  logic [CNT_W-1:0]       cnt [2];
  logic [CNT_W:0]         nxt [2];
  logic [1:0] in_en, dn_full, full, has_sel, is_ej, ej, fwd, hreq, vc_go, host_go, contest, drop_in, drop_host, tog, out_en;
  logic host_self;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NUM_VC);
  endfunction

  assign in_data[0]            = left_data_in;
  assign in_data[1]            = right_data_in;
  assign in_en                 = {right_enable_in, left_enable_in};
  assign dn_full               = {left_in_buffer_full, right_in_buffer_full};
  assign right_data_out        = out_q[0];
  assign left_data_out         = out_q[1];
  assign right_enable_out      = out_en[0];
  assign left_enable_out       = out_en[1];
  assign left_out_buffer_full  = full[0];
  assign right_out_buffer_full = full[1];
  assign lr_drop_cnt           = cnt[0];
  assign rl_drop_cnt           = cnt[1];
  assign host_ready            = host_self || (|host_go);

  // slot selection, free-slot search and grant decisions for both directions
  always_comb begin
    host_self = host_enable_in && host_data_in[ROUTER_BITS-1:0] == ID;
    for (int d = 0; d < 2; d++) begin
      full[d] = &vld[d];
      has_sel[d] = 1'b0;
      sel[d] = '0;
      widx[d] = '0;
      for (int k = NUM_VC - 1; k >= 0; k--) begin
        if (vld[d][wrap(int'(rr[d]) + k)]) begin
          has_sel[d] = 1'b1;
          sel[d] = wrap(int'(rr[d]) + k);
        end
        if (!vld[d][k]) widx[d] = PW'(k);
      end
      sel_data[d] = mem[d][sel[d]];
      is_ej[d] = has_sel[d] && sel_data[d][ROUTER_BITS-1:0] == ID;
      fwd[d] = has_sel[d] && !is_ej[d];
      hreq[d] = host_enable_in && !host_self && host_dir == 1'(d);
      contest[d] = fwd[d] && hreq[d] && !dn_full[d];
      vc_go[d] = fwd[d] && !dn_full[d] && !(hreq[d] && tog[d]);
      host_go[d] = hreq[d] && !dn_full[d] && !(fwd[d] && !tog[d]);
      drop_in[d] = in_en[d] && full[d];
      drop_host[d] = host_self && host_dir == 1'(d);
      nxt[d] = {1'b0, cnt[d]} + (CNT_W+1)'(drop_in[d]) + (CNT_W+1)'(drop_host[d]);
    end
    ej[0] = is_ej[0];
    ej[1] = is_ej[1] && !is_ej[0];
  end

  // packet payload storage, written into the lowest free slot
  always_ff @(posedge clk)
    for (int d = 0; d < 2; d++)
      if (in_en[d] && !full[d]) mem[d][widx[d]] <= in_data[d];

  // slot valid bits, round-robin pointers, link/host outputs and drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        vld[d] <= '0;
        rr[d] <= '0;
        out_q[d] <= '0;
        cnt[d] <= '0;
      end
      tog <= '0;
      out_en <= '0;
      host_valid_out <= 1'b0;
      host_data_out <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (vc_go[d] || ej[d]) begin
          vld[d][sel[d]] <= 1'b0;
          rr[d] <= sel[d] == PW'(NUM_VC - 1) ? '0 : sel[d] + 1'b1;
        end
        if (in_en[d] && !full[d]) vld[d][widx[d]] <= 1'b1;
        if (contest[d]) tog[d] <= ~tog[d];
        out_en[d] <= vc_go[d] || host_go[d];
        if (vc_go[d]) out_q[d] <= sel_data[d];
        else if (host_go[d]) out_q[d] <= host_data_in;
        cnt[d] <= nxt[d][CNT_W] ? '1 : nxt[d][CNT_W-1:0];
      end
      host_valid_out <= |ej;
      if (|ej) host_data_out <= ej[0] ? sel_data[0] : sel_data[1];
    end
  end
endmodule

// File: tb/tb_ring_vc_router.sv
// tb_ring_vc_router: directed checks of forwarding, eject arbitration, backpressure, injection fairness and drop saturation
module tb_ring_vc_router;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] left_data_in, right_data_in, host_data_in;
  logic       left_enable_in, right_enable_in, host_enable_in, host_dir;
  logic       right_in_buffer_full, left_in_buffer_full;
  logic [7:0] right_data_out, left_data_out, host_data_out;
  logic       right_enable_out, left_enable_out, host_valid_out, host_ready;
  logic       left_out_buffer_full, right_out_buffer_full;
  logic [1:0] lr_drop_cnt, rl_drop_cnt;
  int n_vec = 0;
  int n_err = 0;

  ring_vc_router #(.ROUTER_ID(1), .PACKET_SIZE(8), .ROUTER_BITS(2), .NUM_VC(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .left_data_in(left_data_in), .left_enable_in(left_enable_in), .left_out_buffer_full(left_out_buffer_full),
    .right_data_out(right_data_out), .right_enable_out(right_enable_out), .right_in_buffer_full(right_in_buffer_full),
    .right_data_in(right_data_in), .right_enable_in(right_enable_in), .right_out_buffer_full(right_out_buffer_full),
    .left_data_out(left_data_out), .left_enable_out(left_enable_out), .left_in_buffer_full(left_in_buffer_full),
    .host_data_in(host_data_in), .host_enable_in(host_enable_in), .host_dir(host_dir), .host_ready(host_ready),
    .host_data_out(host_data_out), .host_valid_out(host_valid_out),
    .lr_drop_cnt(lr_drop_cnt), .rl_drop_cnt(rl_drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    {left_data_in, right_data_in, host_data_in} = '0;
    {left_enable_in, right_enable_in, host_enable_in, host_dir} = '0;
    {right_in_buffer_full, left_in_buffer_full} = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    n_vec++; if ({right_enable_out, left_enable_out, host_valid_out, left_out_buffer_full, right_out_buffer_full} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b want 00000", {right_enable_out, left_enable_out, host_valid_out, left_out_buffer_full, right_out_buffer_full}); end
    left_data_in = 8'hA2; left_enable_in = 1'b1; tick();
    left_enable_in = 1'b0; tick();
    right_in_buffer_full = 1'b1;
    left_enable_in = 1'b1; left_data_in = 8'h22; tick();
    left_data_in = 8'h23; tick();
    left_data_in = 8'h24; tick();
    left_enable_in = 1'b0;
    n_vec++; if (left_out_buffer_full !== 1'b1) begin n_err++; $display("FAIL pre_reset_full got %b want 1", left_out_buffer_full); end
    n_vec++; if (right_data_out !== 8'hA2) begin n_err++; $display("FAIL pre_reset_data got %h want a2", right_data_out); end
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if ({left_out_buffer_full, right_out_buffer_full} !== 2'b00) begin n_err++; $display("FAIL async_full got %b want 00", {left_out_buffer_full, right_out_buffer_full}); end
    n_vec++; if ({right_data_out, left_data_out, host_data_out} !== 24'h0) begin n_err++; $display("FAIL async_data got %h want 000000", {right_data_out, left_data_out, host_data_out}); end
    n_vec++; if ({lr_drop_cnt, rl_drop_cnt} !== 4'h0) begin n_err++; $display("FAIL async_cnt got %h want 0", {lr_drop_cnt, rl_drop_cnt}); end
    tick();
    rst_n = 1'b1; right_in_buffer_full = 1'b0;
    tick(); tick();
    n_vec++; if (right_enable_out !== 1'b0) begin n_err++; $display("FAIL reset_discard got %b want 0", right_enable_out); end
  endtask

  task automatic test_forward;
    apply_reset();
    left_data_in = 8'hA2; left_enable_in = 1'b1; tick();
    left_enable_in = 1'b0;
    n_vec++; if (right_enable_out !== 1'b0) begin n_err++; $display("FAIL fwd_early got %b want 0", right_enable_out); end
    tick();
    n_vec++; if ({right_enable_out, right_data_out} !== {1'b1, 8'hA2}) begin n_err++; $display("FAIL fwd_out got %b/%h want 1/a2", right_enable_out, right_data_out); end
    tick();
    n_vec++; if ({right_enable_out, right_data_out} !== {1'b0, 8'hA2}) begin n_err++; $display("FAIL fwd_hold got %b/%h want 0/a2", right_enable_out, right_data_out); end
    n_vec++; if (lr_drop_cnt !== 2'd0) begin n_err++; $display("FAIL fwd_drop got %0d want 0", lr_drop_cnt); end
  endtask

  task automatic test_eject;
    apply_reset();
    left_data_in = 8'h51; right_data_in = 8'h61; left_enable_in = 1'b1; right_enable_in = 1'b1; tick();
    left_enable_in = 1'b0; right_enable_in = 1'b0; tick();
    n_vec++; if ({host_valid_out, host_data_out} !== {1'b1, 8'h51}) begin n_err++; $display("FAIL eject_lr got %b/%h want 1/51", host_valid_out, host_data_out); end
    tick();
    n_vec++; if ({host_valid_out, host_data_out} !== {1'b1, 8'h61}) begin n_err++; $display("FAIL eject_rl got %b/%h want 1/61", host_valid_out, host_data_out); end
    tick();
    n_vec++; if ({host_valid_out, right_enable_out, left_enable_out} !== 3'b000) begin n_err++; $display("FAIL eject_idle got %b want 000", {host_valid_out, right_enable_out, left_enable_out}); end
  endtask

  task automatic test_backpressure;
    apply_reset();
    right_in_buffer_full = 1'b1;
    left_enable_in = 1'b1; left_data_in = 8'h02; tick();
    left_data_in = 8'h03; tick();
    n_vec++; if (left_out_buffer_full !== 1'b1) begin n_err++; $display("FAIL bp_full got %b want 1", left_out_buffer_full); end
    left_data_in = 8'h04; tick();
    left_enable_in = 1'b0; right_in_buffer_full = 1'b0;
    n_vec++; if (lr_drop_cnt !== 2'd1) begin n_err++; $display("FAIL bp_drop got %0d want 1", lr_drop_cnt); end
    n_vec++; if (right_enable_out !== 1'b0) begin n_err++; $display("FAIL bp_stall got %b want 0", right_enable_out); end
    tick();
    n_vec++; if ({right_enable_out, right_data_out} !== {1'b1, 8'h02}) begin n_err++; $display("FAIL bp_first got %b/%h want 1/02", right_enable_out, right_data_out); end
    n_vec++; if (left_out_buffer_full !== 1'b0) begin n_err++; $display("FAIL bp_unfull got %b want 0", left_out_buffer_full); end
    tick();
    n_vec++; if ({right_enable_out, right_data_out} !== {1'b1, 8'h03}) begin n_err++; $display("FAIL bp_second got %b/%h want 1/03", right_enable_out, right_data_out); end
  endtask

  task automatic test_injection;
    apply_reset();
    left_data_in = 8'h03; left_enable_in = 1'b1; tick();
    left_enable_in = 1'b0; host_data_in = 8'h00; host_dir = 1'b0; host_enable_in = 1'b1;
    #1;
    n_vec++; if (host_ready !== 1'b0) begin n_err++; $display("FAIL inj_ready1 got %b want 0", host_ready); end
    tick();
    n_vec++; if ({right_enable_out, right_data_out} !== {1'b1, 8'h03}) begin n_err++; $display("FAIL inj_vc got %b/%h want 1/03", right_enable_out, right_data_out); end
    n_vec++; if (host_ready !== 1'b1) begin n_err++; $display("FAIL inj_ready2 got %b want 1", host_ready); end
    tick();
    host_enable_in = 1'b0;
    n_vec++; if ({right_enable_out, right_data_out} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL inj_host got %b/%h want 1/00", right_enable_out, right_data_out); end
  endtask

  task automatic test_host_self;
    apply_reset();
    host_data_in = 8'h41; host_dir = 1'b1; host_enable_in = 1'b1;
    #1;
    n_vec++; if (host_ready !== 1'b1) begin n_err++; $display("FAIL self_ready got %b want 1", host_ready); end
    tick();
    host_enable_in = 1'b0;
    n_vec++; if ({rl_drop_cnt, lr_drop_cnt} !== {2'd1, 2'd0}) begin n_err++; $display("FAIL self_cnt got %0d/%0d want 1/0", rl_drop_cnt, lr_drop_cnt); end
    n_vec++; if ({left_enable_out, host_valid_out} !== 2'b00) begin n_err++; $display("FAIL self_out got %b want 00", {left_enable_out, host_valid_out}); end
  endtask

  task automatic test_saturation;
    apply_reset();
    right_in_buffer_full = 1'b1; left_enable_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      left_data_in = 8'h02 | 8'(i << 4);
      tick();
      if (i == 3) begin
        n_vec++; if (lr_drop_cnt !== 2'd2) begin n_err++; $display("FAIL sat_mid got %0d want 2", lr_drop_cnt); end
      end
    end
    left_enable_in = 1'b0;
    n_vec++; if (lr_drop_cnt !== 2'b11) begin n_err++; $display("FAIL sat_cnt got %b want 11", lr_drop_cnt); end
    n_vec++; if (rl_drop_cnt !== 2'd0) begin n_err++; $display("FAIL sat_rl got %0d want 0", rl_drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_eject();
    test_backpressure();
    test_injection();
    test_host_self();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
